// File: rtl/data_memory_sequencer.sv
// Data-memory access sequencer: drives a synchronous-read word RAM, performs
// two-cycle loads and read-modify-write sub-word stores, and flags illegal requests.
package data_memory_sequencer_pkg;
  typedef enum logic [1:0] {
    MEM_NOP           = 2'd0,
    MEM_LOAD          = 2'd1,
    MEM_STORE_PRELOAD = 2'd2,
    MEM_STORE         = 2'd3
  } MemoryMode_t;
endpackage

module data_memory_sequencer
  import data_memory_sequencer_pkg::*;
#(
  parameter int RAM_A_WIDTH = 12
) (
  input  logic                   clock,
  input  logic                   reset,
  input  MemoryMode_t            memoryMode,
  input  logic [2:0]             funct3,
  input  logic [31:0]            address,
  input  logic [31:0]            storeData,
  output logic [31:0]            loadData,
  output logic [RAM_A_WIDTH-1:0] ramAddress,
  output logic                   ramWriteEnable,
  output logic [31:0]            ramWriteData,
  input  logic [31:0]            ramReadData,
  output logic                   memoryUnalignedAccess,
  output logic                   memoryBadFunct3,
  output logic                   memorySequenceError
);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_LOAD_WAIT    = 2'd1,
    S_PRELOAD_WAIT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             cap_offset_q, cap_offset_d;
  logic [2:0]             cap_funct3_q, cap_funct3_d;
  logic [RAM_A_WIDTH-1:0] cap_word_addr_q, cap_word_addr_d;
  logic [31:0]            load_buffer_q, load_buffer_d;
  logic                   seq_error_q, seq_error_d;

  logic        load_f3_ok;
  logic        store_f3_ok;
  logic        req_active;
  logic        req_bad_f3;
  logic        req_unaligned;
  logic        seq_hit;
  logic        capture;
  logic [31:0] lane_data;
  logic [31:0] merged_word;
  logic        unused_address_bits;

  // Only the low address bits select a word; higher bits alias so accesses wrap.
  assign unused_address_bits = ^address[31:RAM_A_WIDTH+2];

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = 16'(word >> {off[1], 4'b0000});
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [1:0]  off,
                                             input logic [2:0]  f3,
                                             input logic [31:0] data);
    logic [31:0] mask;
    logic [31:0] ins;
    if (f3[1:0] == 2'b00) begin
      mask = 32'h0000_00FF << {off, 3'b000};
      ins  = {24'h0, data[7:0]} << {off, 3'b000};
    end else begin
      mask = 32'h0000_FFFF << {off[1], 4'b0000};
      ins  = {16'h0, data[15:0]} << {off[1], 4'b0000};
    end
    return (word & ~mask) | ins;
  endfunction

  // Request checks look only at the live inputs and only while a new request can start.
  assign load_f3_ok    = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign store_f3_ok   = funct3 inside {3'b000, 3'b001, 3'b010};
  assign req_active    = (state_q == S_IDLE) && (memoryMode != MEM_NOP);
  assign req_bad_f3    = req_active &&
                         ((memoryMode == MEM_LOAD) ? !load_f3_ok : !store_f3_ok);
  assign req_unaligned = req_active && !req_bad_f3 && misaligned(funct3, address[1:0]);

  assign lane_data   = extract_lane(ramReadData, cap_offset_q, cap_funct3_q);
  assign merged_word = merge_lane(ramReadData, cap_offset_q, cap_funct3_q, storeData);

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    state_d         = state_q;
    cap_offset_d    = cap_offset_q;
    cap_funct3_d    = cap_funct3_q;
    cap_word_addr_d = cap_word_addr_q;
    load_buffer_d   = load_buffer_q;
    seq_hit         = 1'b0;
    capture         = 1'b0;
    ramAddress      = cap_word_addr_q;
    ramWriteEnable  = 1'b0;
    ramWriteData    = storeData;
    loadData        = load_buffer_q;

    unique case (state_q)
      S_IDLE: begin
        ramAddress = address[RAM_A_WIDTH+1:2];
        case (memoryMode)
          MEM_LOAD: begin
            if (!req_bad_f3 && !req_unaligned) begin
              state_d = S_LOAD_WAIT;
              capture = 1'b1;
            end
          end
          MEM_STORE_PRELOAD: begin
            // Only sub-word stores need the preload read.
            if (req_bad_f3 || funct3 == 3'b010) begin
              seq_hit = 1'b1;
            end else if (!req_unaligned) begin
              state_d = S_PRELOAD_WAIT;
              capture = 1'b1;
            end
          end
          MEM_STORE: begin
            if (funct3 == 3'b000 || funct3 == 3'b001) begin
              seq_hit = 1'b1;
            end else if (!req_bad_f3 && !req_unaligned) begin
              ramWriteEnable = 1'b1;
            end
          end
          default: ;
        endcase
      end

      S_LOAD_WAIT: begin
        state_d = S_IDLE;
        if (memoryMode == MEM_LOAD) begin
          loadData      = lane_data;
          load_buffer_d = lane_data;
        end else begin
          seq_hit = 1'b1;
        end
      end

      S_PRELOAD_WAIT: begin
        state_d = S_IDLE;
        if (memoryMode == MEM_STORE) begin
          ramWriteEnable = 1'b1;
          ramWriteData   = merged_word;
        end else begin
          seq_hit = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      cap_offset_d    = address[1:0];
      cap_funct3_d    = funct3;
      cap_word_addr_d = address[RAM_A_WIDTH+1:2];
    end

    if (req_bad_f3 || req_unaligned || seq_hit) begin
      ramWriteEnable = 1'b0;
      state_d        = S_IDLE;
    end

    seq_error_d           = seq_error_q | seq_hit;
    memoryBadFunct3       = req_bad_f3;
    memoryUnalignedAccess = req_unaligned;

    // The state may still be a WAIT state during the reset cycle; nothing may escape it.
    if (!reset) begin
      ramWriteEnable        = 1'b0;
      memoryBadFunct3       = 1'b0;
      memoryUnalignedAccess = 1'b0;
    end
  end

  assign memorySequenceError = seq_error_q;

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q         <= S_IDLE;
      cap_offset_q    <= '0;
      cap_funct3_q    <= '0;
      cap_word_addr_q <= '0;
      load_buffer_q   <= '0;
      seq_error_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cap_offset_q    <= cap_offset_d;
      cap_funct3_q    <= cap_funct3_d;
      cap_word_addr_q <= cap_word_addr_d;
      load_buffer_q   <= load_buffer_d;
      seq_error_q     <= seq_error_d;
    end
  end

endmodule

// File: tb/tb_data_memory_sequencer.sv
// Scoreboard bench: transaction tasks push per-cycle expectations from a byte-array
// memory model; a negedge monitor pops and compares them against the DUT outputs.
module tb_data_memory_sequencer;
  import data_memory_sequencer_pkg::*;

  logic        clock;
  logic        reset;
  MemoryMode_t memoryMode;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] storeData;
  logic [31:0] loadData;
  logic [11:0] ramAddress;
  logic        ramWriteEnable;
  logic [31:0] ramWriteData;
  logic [31:0] ramReadData;
  logic        memoryUnalignedAccess;
  logic        memoryBadFunct3;
  logic        memorySequenceError;

  data_memory_sequencer #(.RAM_A_WIDTH(12)) dut (
    .clock                (clock),
    .reset                (reset),
    .memoryMode           (memoryMode),
    .funct3               (funct3),
    .address              (address),
    .storeData            (storeData),
    .loadData             (loadData),
    .ramAddress           (ramAddress),
    .ramWriteEnable       (ramWriteEnable),
    .ramWriteData         (ramWriteData),
    .ramReadData          (ramReadData),
    .memoryUnalignedAccess(memoryUnalignedAccess),
    .memoryBadFunct3      (memoryBadFunct3),
    .memorySequenceError  (memorySequenceError)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Synchronous-read RAM the DUT talks to; a side port fills it during reset.
  logic [31:0] mem [0:4095];
  logic        init_en;
  logic [11:0] init_addr;
  logic [31:0] init_data;

  always @(posedge clock) begin
    if (init_en) mem[init_addr] <= init_data;
    else if (ramWriteEnable) mem[ramAddress] <= ramWriteData;
    ramReadData <= mem[ramAddress];
  end

  // Reference model: byte-addressed memory, load buffer and sticky error flag.
  logic [7:0]  ref_mem [0:16383];
  logic [31:0] model_buf;
  logic        model_seq;

  typedef struct {
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        unal;
    logic        bad;
    logic [31:0] ld;
    logic        seq;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int unsigned byte_index(input logic [31:0] a);
    return int'(a % 32'd16384);
  endfunction

  function automatic logic [11:0] word_index(input logic [31:0] a);
    return 12'((a / 32'd4) % 32'd4096);
  endfunction

  function automatic int unsigned access_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [31:0] a);
    return (a % access_size(f3)) != 0;
  endfunction

  function automatic logic load_ok(input logic [2:0] f3);
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    int unsigned base;
    base = int'(word_index(a)) * 4;
    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int unsigned i;
    logic [7:0]  b;
    logic [15:0] h;
    i = byte_index(a);
    b = ref_mem[i];
    h = (f3[1:0] == 2'b01) ? {ref_mem[i+1], ref_mem[i]} : 16'h0;
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'h0, b};
      3'd5:    return {16'h0, h};
      default: return word_of(a);
    endcase
  endfunction

  task automatic model_write(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int unsigned i;
    i = byte_index(a);
    for (int k = 0; k < int'(access_size(f3)); k++) ref_mem[i+k] = d[8*k +: 8];
  endtask

  task automatic cyc(input MemoryMode_t m, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d, input logic r);
    @(posedge clock);
    #1;
    memoryMode = m;
    funct3     = f;
    address    = a;
    storeData  = d;
    reset      = r;
  endtask

  task automatic push(input logic we, input logic [11:0] wa, input logic [31:0] wd,
                      input logic un, input logic bd);
    exp_t e;
    e.we    = we;
    e.waddr = wa;
    e.wdata = wd;
    e.unal  = un;
    e.bad   = bd;
    e.ld    = model_buf;
    e.seq   = model_seq;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] rand_addr(input logic aligned_word);
    logic [31:0] a;
    a = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 63)) << 2);
    if (!aligned_word) a = a | 32'($urandom_range(0, 3));
    return a;
  endfunction

  function automatic MemoryMode_t pick_other(input MemoryMode_t keep_out);
    MemoryMode_t m;
    do m = MemoryMode_t'($urandom_range(0, 3)); while (m == keep_out);
    return m;
  endfunction

  task automatic t_nop();
    cyc(MEM_NOP, 3'($urandom), $urandom, $urandom, 1'b1);
    push(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic t_load(input logic [2:0] f3, input logic [31:0] a);
    logic bd, un;
    cyc(MEM_LOAD, f3, a, $urandom, 1'b1);
    bd = !load_ok(f3);
    un = !bd && is_misaligned(f3, a);
    push(1'b0, '0, '0, un, bd);
    if (bd || un) return;
    cyc(MEM_LOAD, 3'($urandom), $urandom, $urandom, 1'b1);
    model_buf = model_load(f3, a);
    push(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic t_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic un;
    un = is_misaligned(f3, a);
    if (f3 == 3'd2) begin
      cyc(MEM_STORE, f3, a, d, 1'b1);
      if (!un) model_write(f3, a, d);
      push(!un, word_index(a), word_of(a), un, 1'b0);
    end else begin
      cyc(MEM_STORE_PRELOAD, f3, a, $urandom, 1'b1);
      push(1'b0, '0, '0, un, 1'b0);
      if (un) return;
      cyc(MEM_STORE, 3'($urandom), $urandom, d, 1'b1);
      model_write(f3, a, d);
      push(1'b1, word_index(a), word_of(a), 1'b0, 1'b0);
    end
  endtask

  // STORE of a sub-word width without the preload step.
  task automatic t_store_seq(input logic [2:0] f3, input logic [31:0] a);
    cyc(MEM_STORE, f3, a, $urandom, 1'b1);
    push(1'b0, '0, '0, is_misaligned(f3, a), 1'b0);
    model_seq = 1'b1;
  endtask

  // STORE_PRELOAD with sw or an illegal width.
  task automatic t_preload_bad(input logic [2:0] f3, input logic [31:0] a);
    logic bd;
    bd = !(f3 inside {3'd0, 3'd1, 3'd2});
    cyc(MEM_STORE_PRELOAD, f3, a, $urandom, 1'b1);
    push(1'b0, '0, '0, !bd && is_misaligned(f3, a), bd);
    model_seq = 1'b1;
  endtask

  task automatic t_store_badf3(input logic [2:0] f3, input logic [31:0] a);
    cyc(MEM_STORE, f3, a, $urandom, 1'b1);
    push(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic t_load_abort();
    logic [31:0] a;
    a = rand_addr(1'b1);
    cyc(MEM_LOAD, 3'd2, a, $urandom, 1'b1);
    push(1'b0, '0, '0, 1'b0, 1'b0);
    cyc(pick_other(MEM_LOAD), 3'($urandom), $urandom, $urandom, 1'b1);
    push(1'b0, '0, '0, 1'b0, 1'b0);
    model_seq = 1'b1;
  endtask

  task automatic t_preload_abort();
    logic [31:0] a;
    a = rand_addr(1'b1);
    cyc(MEM_STORE_PRELOAD, 3'($urandom_range(0, 1)), a, $urandom, 1'b1);
    push(1'b0, '0, '0, 1'b0, 1'b0);
    cyc(pick_other(MEM_STORE), 3'($urandom), $urandom, $urandom, 1'b1);
    push(1'b0, '0, '0, 1'b0, 1'b0);
    model_seq = 1'b1;
  endtask

  // Reset lands while the sub-word store waits on its preload read.
  task automatic t_reset_mid();
    logic [2:0] f3;
    f3 = 3'($urandom_range(0, 1));
    cyc(MEM_STORE_PRELOAD, f3, rand_addr(1'b1), $urandom, 1'b1);
    push(1'b0, '0, '0, 1'b0, 1'b0);
    cyc(MEM_STORE, f3, $urandom, $urandom, 1'b0);
    push(1'b0, '0, '0, 1'b0, 1'b0);
    model_buf = '0;
    model_seq = 1'b0;
    t_nop();
  endtask

  // An illegal request presented during reset must not raise any flag.
  task automatic t_reset_idle();
    cyc(MEM_LOAD, 3'd3, 32'h6, $urandom, 1'b0);
    push(1'b0, '0, '0, 1'b0, 1'b0);
    model_buf = '0;
    model_seq = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("write_enable", 32'(ramWriteEnable), 32'(e.we));
        if (e.we) begin
          check("write_addr", 32'(ramAddress), 32'(e.waddr));
          check("write_data", ramWriteData, e.wdata);
        end
        check("unaligned_flag", 32'(memoryUnalignedAccess), 32'(e.unal));
        check("bad_funct3_flag", 32'(memoryBadFunct3), 32'(e.bad));
        check("load_data", loadData, e.ld);
        check("sequence_error", 32'(memorySequenceError), 32'(e.seq));
      end
    end
  end

  initial begin : driver
    logic [31:0] w;
    int          pick;
    reset      = 1'b0;
    memoryMode = MEM_NOP;
    funct3     = '0;
    address    = '0;
    storeData  = '0;
    init_en    = 1'b0;
    init_addr  = '0;
    init_data  = '0;
    model_buf  = '0;
    model_seq  = 1'b0;

    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if (i == 0) w = 32'h80FF_7F01;
      if (i == 4) w = 32'h1122_3344;
      @(posedge clock);
      #1;
      init_en   = 1'b1;
      init_addr = 12'(i);
      init_data = w;
      for (int k = 0; k < 4; k++) ref_mem[i*4+k] = w[8*k +: 8];
    end
    @(posedge clock);
    #1;
    init_en = 1'b0;

    // Reset state, then the directed cases.
    cyc(MEM_NOP, '0, '0, '0, 1'b0);
    push(1'b0, '0, '0, 1'b0, 1'b0);
    t_reset_idle();
    t_nop();
    t_load(3'd0, 32'h3);
    t_load(3'd4, 32'h3);
    t_load(3'd1, 32'h2);
    t_load(3'd5, 32'h0);
    t_store(3'd0, 32'h11, 32'hAB);
    t_load(3'd2, 32'h10);
    t_store(3'd2, 32'h8, 32'hDEAD_BEEF);
    t_nop();
    t_load(3'd2, 32'h8);
    t_load(3'd2, 32'h6);
    t_load(3'd3, 32'h0);
    t_store_seq(3'd1, 32'h20);
    repeat (3) t_nop();
    t_reset_mid();
    t_load(3'd2, 32'h0001_0010);

    for (int n = 0; n < 600; n++) begin
      pick = $urandom_range(0, 99);
      if (pick < 35)      t_load(3'($urandom), rand_addr(1'b0));
      else if (pick < 65) t_store(3'($urandom_range(0, 2)), rand_addr(1'b0), $urandom);
      else if (pick < 75) t_nop();
      else if (pick < 79) t_store_seq(3'($urandom_range(0, 1)), rand_addr(1'b0));
      else if (pick < 83) t_preload_bad(3'($urandom_range(2, 7)), rand_addr(1'b0));
      else if (pick < 87) t_store_badf3(3'($urandom_range(3, 7)), rand_addr(1'b0));
      else if (pick < 90) t_load_abort();
      else if (pick < 93) t_preload_abort();
      else if (pick < 97) t_reset_mid();
      else                t_reset_idle();
    end
    t_nop();

    @(posedge clock);
    @(negedge clock);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
